uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an integrated write FIFO and runtime-selectable parity and stop-bit count. It sits beside `baud_gen` and consumes its `baud_tick_1x` pulse. It replaces the single-byte `uart_tx` wherever the host must queue several characters and needs 5–9 bit frames.

---
 rtl/uart_tx_fifo.sv | 190 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a FIFO_DEPTH write queue, 5..9 data bits, optional parity and 1/2 stop bits.
// Bits advance only on baud_tick_1x with tx_line/tx_busy registered; writes to a full queue are dropped and flagged by overflow.
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        baud_tick_1x,
  input  logic                        parity_en,
  input  logic                        parity_odd,
  input  logic                        stop2,
  input  logic                        wr_en,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        tx_busy,
  output logic                        tx_done,
  output logic                        tx_line
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP1  = 3'd4;
  localparam logic [2:0] S_STOP2  = 3'd5;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              stop2_q, stop2_d;
  logic              line_q, line_d;

  logic              fifo_empty;
  logic              frame_end;
  logic              pop;
  logic              push;
  logic [DATA_W-1:0] head;

  assign head       = mem_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  assign full       = (count_q == DEPTH_C);

  // The tick that ends the last stop bit may immediately start the next frame.
  assign frame_end = baud_tick_1x &&
                     (((state_q == S_STOP1) && !stop2_q) || (state_q == S_STOP2));
  assign pop  = baud_tick_1x && en && !fifo_empty && ((state_q == S_IDLE) || frame_end);
  assign push = wr_en && (!full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = wr_en && !push;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    line_d    = line_q;
    if (baud_tick_1x) begin
      case (state_q)
        S_IDLE: begin
          line_d = 1'b1;
        end
        S_START: begin
          state_d = S_DATA;
          line_d  = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
        end
        S_DATA: begin
          if (bit_q == LAST_BIT) begin
            if (par_en_q) begin
              state_d = S_PARITY;
              line_d  = par_bit_q;
            end else begin
              state_d = S_STOP1;
              line_d  = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            line_d  = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
        S_PARITY: begin
          state_d = S_STOP1;
          line_d  = 1'b1;
        end
        S_STOP1: begin
          state_d = stop2_q ? S_STOP2 : S_IDLE;
          line_d  = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
          line_d  = 1'b1;
        end
      endcase
    end
    // Frame configuration is captured only here so mid-frame changes wait for the next frame.
    if (pop) begin
      state_d   = S_START;
      line_d    = 1'b0;
      shift_d   = head;
      par_en_d  = parity_en;
      par_bit_d = (^head) ^ parity_odd;
      stop2_d   = stop2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      line_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_q     <= bit_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      line_q    <= line_d;
    end
  end

  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign tx_busy    = (state_q != S_IDLE);
  assign tx_done    = frame_end;
  assign tx_line    = line_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-of-bits frame model checked every cycle, plus literal frame checks.
module tb_uart_tx_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n, en, baud_tick_1x, parity_en, parity_odd, stop2, wr_en;
  logic [DW-1:0] wr_data;
  logic          full, overflow, tx_busy, tx_done, tx_line;
  logic [2:0]    fifo_count;

  uart_tx_fifo #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .baud_tick_1x(baud_tick_1x),
    .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .wr_en(wr_en), .wr_data(wr_data), .full(full), .fifo_count(fifo_count),
    .overflow(overflow), .tx_busy(tx_busy), .tx_done(tx_done), .tx_line(tx_line)
  );

  always #5 clk = ~clk;

  // Model: queued characters, and the remaining bits of the frame on the line (front = current bit).
  logic [DW-1:0] m_fifo[$];
  bit            m_frame[$];
  bit            m_busy, m_line, m_ovf;

  bit  want_rst, want_en, want_pe, want_po, want_s2;
  int  tick_div, tick_cnt;
  int  checks, failures;
  bit  cap[$];
  bit  prev_tick;
  int  done_cnt, busy_cycles, ovf_cnt;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_frame.delete();
    m_busy = 1'b0;
    m_line = 1'b1;
    m_ovf  = 1'b0;
  endtask

  task automatic clear_stats();
    cap.delete();
    done_cnt    = 0;
    busy_cycles = 0;
    ovf_cnt     = 0;
  endtask

  function automatic logic [31:0] cap_vec(input int first, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) begin
      if (first + i < cap.size()) v[i] = cap[first + i];
    end
    return v;
  endfunction

  // One clock: compare registered outputs, drive inputs, compare tx_done, advance the model.
  task automatic step(input bit w, input logic [DW-1:0] d);
    bit            pop, acc, last, dummy;
    logic [DW-1:0] c;
    @(negedge clk);
    chk("tx_line", tx_line, m_line);
    chk("tx_busy", tx_busy, m_busy);
    chk("full", full, m_fifo.size() == DEPTH);
    chk("fifo_count", fifo_count, m_fifo.size());
    chk("overflow", overflow, m_ovf);
    if (prev_tick && tx_busy) cap.push_back(tx_line);
    if (tx_busy) busy_cycles++;
    if (overflow) ovf_cnt++;

    rst_n      = want_rst;
    en         = want_en;
    parity_en  = want_pe;
    parity_odd = want_po;
    stop2      = want_s2;
    wr_en      = w;
    wr_data    = d;
    if (tick_div == 0) begin
      baud_tick_1x = ($urandom_range(0, 2) == 0);
    end else begin
      baud_tick_1x = (tick_cnt == tick_div);
      tick_cnt     = (tick_cnt == tick_div) ? 0 : tick_cnt + 1;
    end
    #1;
    last = m_busy && (m_frame.size() == 1);
    chk("tx_done", tx_done, baud_tick_1x && last);
    if (tx_done) done_cnt++;
    prev_tick = baud_tick_1x;

    if (!rst_n) begin
      model_reset();
    end else begin
      pop = baud_tick_1x && en && (m_fifo.size() > 0) && (!m_busy || last);
      acc = w && ((m_fifo.size() < DEPTH) || pop);
      if (baud_tick_1x && m_busy) begin
        dummy = m_frame.pop_front();
        if (m_frame.size() == 0) m_busy = 1'b0;
      end
      if (pop) begin
        c = m_fifo.pop_front();
        m_frame.delete();
        m_frame.push_back(1'b0);
        for (int i = 0; i < DW; i++) m_frame.push_back(c[i]);
        if (parity_en) m_frame.push_back((^c) ^ parity_odd);
        m_frame.push_back(1'b1);
        if (stop2) m_frame.push_back(1'b1);
        m_busy = 1'b1;
      end
      m_line = m_busy ? m_frame[0] : 1'b1;
      if (acc) m_fifo.push_back(d);
      m_ovf = w && !acc;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((m_busy || m_fifo.size() != 0 || tx_busy) && n < budget) begin
      step(1'b0, '0);
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL wait_idle: still busy after %0d cycles, required idle", budget);
    end
    run(3);
  endtask

  task automatic set_cfg(input bit pe, input bit po, input bit s2, input int div);
    want_pe  = pe;
    want_po  = po;
    want_s2  = s2;
    tick_div = div;
    tick_cnt = 0;
  endtask

  initial begin
    checks = 0; failures = 0; prev_tick = 1'b0;
    rst_n = 1'b0; en = 1'b0; baud_tick_1x = 1'b0; parity_en = 1'b0;
    parity_odd = 1'b0; stop2 = 1'b0; wr_en = 1'b0; wr_data = '0;
    want_rst = 1'b0; want_en = 1'b0;
    set_cfg(1'b0, 1'b0, 1'b0, 3);
    model_reset();
    clear_stats();

    // Held in reset while clocks and ticks run.
    run(4);
    chk("rst_line", tx_line, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_count", fifo_count, 0);
    want_rst = 1'b1;
    run(2);

    // 8N1, 0xA5, 33 clk per bit.
    want_en = 1'b1;
    set_cfg(1'b0, 1'b0, 1'b0, 32);
    clear_stats();
    step(1'b1, 8'hA5);
    wait_idle(2000);
    chk("a5_bits", cap.size(), 10);
    chk("a5_frame", cap_vec(0, 10), 32'h34A);
    chk("a5_done", done_cnt, 1);
    chk("a5_busy_clks", busy_cycles, 330);

    // Even parity on 0xA5.
    set_cfg(1'b1, 1'b0, 1'b0, 3);
    clear_stats();
    step(1'b1, 8'hA5);
    wait_idle(500);
    chk("even_bits", cap.size(), 11);
    chk("even_par", cap[9], 0);

    // Odd parity with two stop bits.
    set_cfg(1'b1, 1'b1, 1'b1, 3);
    clear_stats();
    step(1'b1, 8'hA5);
    wait_idle(500);
    chk("odd_bits", cap.size(), 12);
    chk("odd_par", cap[9], 1);
    chk("odd_busy_clks", busy_cycles, 48);

    // Back-to-back frames with no idle bit between them.
    set_cfg(1'b0, 1'b0, 1'b0, 3);
    clear_stats();
    step(1'b1, 8'hA5);
    run(6);
    step(1'b1, 8'hAA);
    wait_idle(500);
    chk("b2b_frames", cap_vec(0, 20), 32'hD534A);
    chk("b2b_done", done_cnt, 2);
    chk("b2b_busy_clks", busy_cycles, 80);

    // Fill while disabled, overflow the fifth write, then drain in order.
    want_en = 1'b0;
    clear_stats();
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    step(1'b1, 8'h33);
    step(1'b1, 8'h44);
    step(1'b1, 8'h55);
    run(2);
    chk("ovf_full", full, 1);
    chk("ovf_count", fifo_count, 4);
    chk("ovf_pulses", ovf_cnt, 1);
    want_en = 1'b1;
    wait_idle(1000);
    chk("drain_done", done_cnt, 4);
    chk("drain_last", cap_vec(31, 8), 32'h44);

    // Disable mid-frame: the frame completes and the queued entry waits.
    clear_stats();
    step(1'b1, 8'h3C);
    step(1'b1, 8'h5A);
    run(8);
    want_en = 1'b0;
    run(80);
    chk("hold_done", done_cnt, 1);
    chk("hold_count", fifo_count, 1);
    chk("hold_busy", tx_busy, 0);

    // Asynchronous reset while a zero data bit is on the line.
    want_en = 1'b1;
    cap.delete();
    for (int n = 0; n < 100 && cap.size() < 2; n++) step(1'b0, '0);
    chk("pre_rst_line", tx_line, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_line", tx_line, 1);
    chk("arst_busy", tx_busy, 0);
    chk("arst_count", fifo_count, 0);
    model_reset();
    want_rst = 1'b0;
    run(3);
    want_rst = 1'b1;
    run(20);

    // Randomized traffic, enables, configurations and tick spacing.
    tick_div = 0;
    for (int i = 0; i < 4000; i++) begin
      want_en = ($urandom_range(0, 9) != 0);
      want_pe = $urandom_range(0, 1) != 0;
      want_po = $urandom_range(0, 1) != 0;
      want_s2 = $urandom_range(0, 1) != 0;
      step($urandom_range(0, 2) == 0, DW'($urandom));
    end
    want_en = 1'b1;
    wait_idle(2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
